// File: rtl/ascii_calc_nd.sv
// ASCII hex calculator core: NDIG-digit operands, '+'/'-' operator, digit echo and
// result characters queued through a small TX FIFO; {carry/borrow, result} shown on leds.
module ascii_calc_nd #(
    parameter int NDIG     = 1,
    parameter int TXQ_LOG2 = 2
) (
    input  logic              clk12m,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_rdy,
    input  logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_data_rdy,
    output logic [4*NDIG:0]   leds,
    output logic              err
);

    localparam int W     = 4 * NDIG;
    localparam int DEPTH = 1 << TXQ_LOG2;
    localparam int CW    = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [2:0] {S_OP1, S_OP2, S_OPR, S_CALC, S_SEND} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic [W-1:0]          op1, op2;
    logic                  op_sub;
    logic                  pend_vld;
    logic [7:0]            pend_byte;

    logic [7:0]            mem [DEPTH];
    logic [TXQ_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [TXQ_LOG2:0]     fifo_cnt;
    logic [TXQ_LOG2+1:0]   occ;

    logic                  is_digit, is_esc, last;
    logic                  take_digit, take_op, esc, drop, send_push;
    logic                  fifo_full, dig_full, pop, push;
    logic [7:0]            wr_byte, res_char;
    logic [3:0]            res_nib;
    logic [W:0]            res_calc;

    assign is_digit  = (rx_data[7:4] == 4'h3);
    assign is_esc    = (rx_data == 8'h1B);
    assign last      = (cnt == CW'(NDIG - 1));
    assign fifo_full = (fifo_cnt == (TXQ_LOG2+1)'(DEPTH));
    // A digit accepted last cycle still occupies a slot until it is written.
    assign occ       = {1'b0, fifo_cnt} + {{(TXQ_LOG2+1){1'b0}}, pend_vld};
    assign dig_full  = (occ >= (TXQ_LOG2+2)'(DEPTH));
    assign pop       = (fifo_cnt != '0) && tx_ready && !tx_data_rdy;
    assign res_calc  = op_sub ? ({1'b0, op1} - {1'b0, op2}) : ({1'b0, op1} + {1'b0, op2});

    always_comb begin
        res_nib = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) res_nib = leds[W-1-4*i -: 4];
        end
        res_char = {((cnt == '0) && leds[W]) ? 4'h5 : 4'h3, res_nib};
    end

    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) state <= S_OP1;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        take_digit = 1'b0;
        take_op    = 1'b0;
        esc        = 1'b0;
        drop       = 1'b0;
        send_push  = 1'b0;
        case (state)
            S_OP1, S_OP2: begin
                if (rx_data_rdy) begin
                    if (is_esc) begin
                        esc        = 1'b1;
                        state_next = S_OP1;
                    end else if (is_digit) begin
                        if (dig_full) begin
                            drop = 1'b1;
                        end else begin
                            take_digit = 1'b1;
                            if (last) state_next = (state == S_OP1) ? S_OP2 : S_OPR;
                        end
                    end
                end
            end
            S_OPR: begin
                if (rx_data_rdy) begin
                    if (is_esc) begin
                        esc        = 1'b1;
                        state_next = S_OP1;
                    end else if (rx_data == 8'h2B || rx_data == 8'h2D) begin
                        take_op    = 1'b1;
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
                drop       = rx_data_rdy;
                state_next = S_SEND;
            end
            S_SEND: begin
                drop = rx_data_rdy;
                if (!fifo_full || pop) begin
                    send_push = 1'b1;
                    if (last) state_next = S_OP1;
                end
            end
            default: state_next = S_OP1;
        endcase
    end

    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op1       <= '0;
            op2       <= '0;
            op_sub    <= 1'b0;
            pend_vld  <= 1'b0;
            pend_byte <= 8'h00;
            leds      <= '0;
            err       <= 1'b0;
        end else begin
            pend_vld <= take_digit;
            if (take_digit) begin
                pend_byte <= rx_data;
                if (state == S_OP1) op1 <= (op1 << 4) | W'(rx_data[3:0]);
                else                op2 <= (op2 << 4) | W'(rx_data[3:0]);
            end
            if (take_digit || send_push) cnt <= last ? '0 : cnt + 1'b1;
            if (esc) begin
                cnt <= '0;
                err <= 1'b0;
            end
            if (drop)    err    <= 1'b1;
            if (take_op) op_sub <= (rx_data == 8'h2D);
            if (state == S_CALC) leds <= res_calc;
        end
    end

    // Digit echoes and result characters never contend: the last echo is written
    // well before the first result character is produced.
    assign wr_byte = pend_vld ? pend_byte : res_char;
    assign push    = (pend_vld || send_push) && (!fifo_full || pop);

    always_ff @(posedge clk12m) begin
        if (push) mem[wr_ptr] <= wr_byte;
    end

    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            tx_data     <= 8'h00;
            tx_data_rdy <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            tx_data_rdy <= pop;
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_calc_nd.sv
// Directed bench for ascii_calc_nd: one NDIG=1 and one NDIG=2 instance sharing clock,
// reset, rx_data and tx_ready; each has its own rx strobe and TX capture queue.
module tb_ascii_calc_nd;

    logic       clk12m = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rdy1, rdy2;
    logic       tx_ready;
    logic [7:0] tx_data1, tx_data2;
    logic       tx_rdy1, tx_rdy2;
    logic [4:0] leds1;
    logic [8:0] leds2;
    logic       err1, err2;

    always #5 clk12m = ~clk12m;

    ascii_calc_nd #(.NDIG(1), .TXQ_LOG2(2)) dut1 (
        .clk12m(clk12m), .rst_n(rst_n), .rx_data(rx_data), .rx_data_rdy(rdy1),
        .tx_ready(tx_ready), .tx_data(tx_data1), .tx_data_rdy(tx_rdy1),
        .leds(leds1), .err(err1)
    );

    ascii_calc_nd #(.NDIG(2), .TXQ_LOG2(2)) dut2 (
        .clk12m(clk12m), .rst_n(rst_n), .rx_data(rx_data), .rx_data_rdy(rdy2),
        .tx_ready(tx_ready), .tx_data(tx_data2), .tx_data_rdy(tx_rdy2),
        .leds(leds2), .err(err2)
    );

    // Bytes are listed MSB-first: byte i sits at bits [63-8*i -: 8].
    typedef struct packed {
        int          ndig;
        int          nrx;
        logic [63:0] rx;
        int          ntx;
        logic [63:0] tx;
        logic [8:0]  leds;
        logic        err;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    logic       prev1 = 1'b0;
    logic       prev2 = 1'b0;

    always @(negedge clk12m) begin
        if (tx_rdy1) begin
            q1.push_back(tx_data1);
            checks++;
            if (prev1) begin
                errors++;
                $display("[TB] FAIL gap1: tx_data_rdy high on consecutive cycles, got 1 required 0");
            end
        end
        if (tx_rdy2) begin
            q2.push_back(tx_data2);
            checks++;
            if (prev2) begin
                errors++;
                $display("[TB] FAIL gap2: tx_data_rdy high on consecutive cycles, got 1 required 0");
            end
        end
        prev1 = tx_rdy1;
        prev2 = tx_rdy2;
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] getq(input int ndig, input int i);
        if (ndig == 1) return (i < q1.size()) ? {24'h0, q1[i]} : 32'hFFFF_FFFF;
        else           return (i < q2.size()) ? {24'h0, q2[i]} : 32'hFFFF_FFFF;
    endfunction

    function automatic int qsize(input int ndig);
        return (ndig == 1) ? q1.size() : q2.size();
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk12m);
    endtask

    task automatic sendByte(input int ndig, input logic [7:0] b);
        @(posedge clk12m); #1;
        rx_data = b;
        rdy1    = (ndig == 1);
        rdy2    = (ndig == 2);
        @(posedge clk12m); #1;
        rdy1 = 1'b0;
        rdy2 = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk12m); #1;
        rdy1  = 1'b0;
        rdy2  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk12m);
        checkOutput("rst_tx_rdy", {30'h0, tx_rdy2, tx_rdy1}, 32'h0);
        checkOutput("rst_tx_data", {16'h0, tx_data2, tx_data1}, 32'h0);
        checkOutput("rst_leds", {18'h0, leds2, leds1}, 32'h0);
        checkOutput("rst_err", {30'h0, err2, err1}, 32'h0);
        idle(2); #1;
        rst_n = 1'b1;
        q1.delete();
        q2.delete();
    endtask

    task automatic waitTx(input int ndig, input int n, input string tag);
        int k = 0;
        while (qsize(ndig) < n && k < 400) begin
            @(negedge clk12m);
            k++;
        end
        if (k >= 400) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d bytes, required %0d", tag, qsize(ndig), n);
        end
        idle(10);
    endtask

    task automatic compareTx(input int ndig, input int ntx, input logic [63:0] tx, input string tag);
        checkOutput({tag, "_count"}, qsize(ndig), ntx);
        for (int i = 0; i < ntx; i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), getq(ndig, i), {24'h0, tx[63-8*i -: 8]});
    endtask

    task automatic applyStimulus(input vec_t v);
        q1.delete();
        q2.delete();
        for (int i = 0; i < v.nrx; i++) begin
            sendByte(v.ndig, v.rx[63-8*i -: 8]);
            idle(2);
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        applyStimulus(v);
        waitTx(v.ndig, v.ntx, tag);
        @(negedge clk12m);
        compareTx(v.ndig, v.ntx, v.tx, tag);
        if (v.ndig == 1) begin
            checkOutput({tag, "_leds"}, {27'h0, leds1}, {23'h0, v.leds});
            checkOutput({tag, "_err"}, {31'h0, err1}, {31'h0, v.err});
        end else begin
            checkOutput({tag, "_leds"}, {23'h0, leds2}, {23'h0, v.leds});
            checkOutput({tag, "_err"}, {31'h0, err2}, {31'h0, v.err});
        end
    endtask

    initial begin
        vec_t t;
        rst_n    = 1'b1;
        rx_data  = 8'h00;
        rdy1     = 1'b0;
        rdy2     = 1'b0;
        tx_ready = 1'b1;

        vecs[0] = '{ndig:1, nrx:3, rx:64'h30342B0000000000, ntx:3, tx:64'h3034340000000000, leds:9'h004, err:1'b0};
        vecs[1] = '{ndig:1, nrx:3, rx:64'h35322D0000000000, ntx:3, tx:64'h3532330000000000, leds:9'h003, err:1'b0};
        vecs[2] = '{ndig:1, nrx:3, rx:64'h32332D0000000000, ntx:3, tx:64'h32335F0000000000, leds:9'h01F, err:1'b0};
        vecs[3] = '{ndig:2, nrx:5, rx:64'h3F3F30312B000000, ntx:6, tx:64'h3F3F303150300000, leds:9'h100, err:1'b0};
        vecs[4] = '{ndig:1, nrx:7, rx:64'h3341311B37372D00, ntx:5, tx:64'h3331373730000000, leds:9'h000, err:1'b0};
        vecs[5] = '{ndig:2, nrx:5, rx:64'h313233342D000000, ntx:6, tx:64'h313233345D3E0000, leds:9'h1DE, err:1'b0};
        vecs[6] = '{ndig:2, nrx:5, rx:64'h383038312B000000, ntx:6, tx:64'h3830383150310000, leds:9'h101, err:1'b0};
        vecs[7] = '{ndig:1, nrx:3, rx:64'h39392B0000000000, ntx:3, tx:64'h3939520000000000, leds:9'h012, err:1'b0};

        for (int v = 0; v < NV; v++) begin
            doReset();
            tx_ready = 1'b1;
            runVector(vecs[v], $sformatf("vec%0d", v));
        end

        // FIFO fills while the transmitter is blocked; the next digit is dropped.
        doReset();
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sendByte(2, 8'h31 + 8'(i));
            idle(2);
        end
        @(negedge clk12m);
        checkOutput("t4_err_before", {31'h0, err2}, 32'h0);
        sendByte(2, 8'h1B);
        idle(2);
        @(negedge clk12m);
        checkOutput("t4_err_after_esc", {31'h0, err2}, 32'h0);
        sendByte(2, 8'h35);
        idle(2);
        @(negedge clk12m);
        checkOutput("t4_err_drop", {31'h0, err2}, 32'h1);
        idle(20);
        checkOutput("t4_held", qsize(2), 32'h0);
        tx_ready = 1'b1;
        waitTx(2, 4, "t4");
        compareTx(2, 4, 64'h3132333400000000, "t4");
        checkOutput("t4_err_sticky", {31'h0, err2}, 32'h1);

        // A byte arriving the cycle after the operator lands in the calculate state.
        doReset();
        tx_ready = 1'b1;
        sendByte(1, 8'h31);
        idle(2);
        sendByte(1, 8'h32);
        idle(2);
        @(posedge clk12m); #1;
        rx_data = 8'h2B;
        rdy1    = 1'b1;
        @(posedge clk12m); #1;
        rx_data = 8'h39;
        @(posedge clk12m); #1;
        rdy1 = 1'b0;
        waitTx(1, 3, "calc_drop");
        compareTx(1, 3, 64'h3132330000000000, "calc_drop");
        checkOutput("calc_drop_leds", {27'h0, leds1}, 32'h03);
        checkOutput("calc_drop_err", {31'h0, err1}, 32'h1);
        t = '{ndig:1, nrx:3, rx:64'h32322B0000000000, ntx:3, tx:64'h3232340000000000, leds:9'h004, err:1'b1};
        runVector(t, "after_drop");

        // Reset while the result is stalled behind a full FIFO.
        doReset();
        tx_ready = 1'b0;
        t = '{ndig:2, nrx:5, rx:64'h313233342B000000, ntx:0, tx:64'h0, leds:9'h046, err:1'b0};
        applyStimulus(t);
        idle(4);
        @(negedge clk12m);
        checkOutput("t6_leds_pre", {23'h0, leds2}, 32'h046);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_tx_rdy", {31'h0, tx_rdy2}, 32'h0);
        checkOutput("t6_rst_leds", {23'h0, leds2}, 32'h0);
        idle(3); #1;
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        idle(20);
        checkOutput("t6_no_stale", qsize(2), 32'h0);
        t = '{ndig:2, nrx:5, rx:64'h303030342B000000, ntx:6, tx:64'h3030303430340000, leds:9'h004, err:1'b0};
        runVector(t, "t6_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
